// File: rtl/irq_arbiter_pkg.sv
// irq_arbiter_pkg
// Shared definitions for the interrupt arbiter: the ID width default (tied to
// the core's irq bus width), the "no request" ID, the reserved exception ID and
// the FSM state encoding.
package irq_arbiter_pkg;

  // Core irq bus width; IRQ_W of the arbiter must match it.
  localparam int IRQ_W_DEF = 8;

  // ID 0 on the request bus means "no request".
  localparam logic [7:0] ID_NONE = 8'h00;

  // ID reserved by the core for exceptions; the arbiter never emits it.
  localparam logic [7:0] ID_EXC = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/irq_sync_edge.sv
// irq_sync_edge
// Vector-wide 2-flop synchroniser followed by a history flop. o_rise is high
// for one cycle when a synchronised line goes from 0 to 1.
// Ports:
//   clk    core clock
//   rst    asynchronous active-high reset
//   i_raw  raw asynchronous lines
//   o_rise per-line one-cycle rising-edge strobe (decoded from registers)
module irq_sync_edge #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i_raw,
  output logic [N-1:0] o_rise
);

  logic [N-1:0] r_sync1;
  logic [N-1:0] r_sync2;
  logic [N-1:0] r_hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_hist  <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  assign o_rise = r_sync2 & ~r_hist;

endmodule

// File: rtl/irq_arbiter.sv
// irq_arbiter
// Interrupt source block feeding the core's external-interrupt request port.
// Edge-detected lines latch as pending; the lowest-index enabled pending
// source is presented as ID k+1 until acknowledged, then the block waits in
// SERVICE until the handler's return is signalled.
//
// Handshake: the request ID is held constant while in REQ; a cycle with
// irq_acknowledge_i high in REQ is the transfer. irq_complete_i is a one-cycle
// pulse that is honoured only in SERVICE. Stray pulses in other states are
// ignored.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   irq_src_i              raw external lines (rising-edge sensitive)
//   irq_mask_i             per-source enable, 1 = eligible
//   irq_flush_req_addr_o   requested source ID, 0 = no request (registered)
//   irq_acknowledge_i      controller has taken the request
//   irq_complete_i         handler return pulse
//   irq_pending_o          pending bits (registered)
//   irq_active_o           interrupt in service (registered)
//   irq_state_o            FSM state, debug visibility
module irq_arbiter
  import irq_arbiter_pkg::*;
#(
  parameter int IRQ_NUM = 8,
  parameter int IRQ_W   = IRQ_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IRQ_NUM-1:0] irq_src_i,
  input  logic [IRQ_NUM-1:0] irq_mask_i,
  output logic [IRQ_W-1:0]   irq_flush_req_addr_o,
  input  logic               irq_acknowledge_i,
  input  logic               irq_complete_i,
  output logic [IRQ_NUM-1:0] irq_pending_o,
  output logic               irq_active_o,
  output logic [1:0]         irq_state_o
);

  state_t             r_state;
  logic [IRQ_W-1:0]   r_req_id;
  logic [IRQ_NUM-1:0] r_pending;
  logic [IRQ_W-1:0]   r_id_out;
  logic               r_active;

  logic [IRQ_NUM-1:0] w_rise;
  logic [IRQ_NUM-1:0] w_eligible;
  logic [IRQ_NUM-1:0] w_clr;
  logic [IRQ_W-1:0]   w_win_id;
  logic               w_found;
  logic               w_ack_fire;
  state_t             w_next_state;
  logic [IRQ_W-1:0]   w_next_req_id;
  logic [IRQ_W-1:0]   w_next_id_out;
  logic               w_next_active;

  irq_sync_edge #(.N(IRQ_NUM)) u_sync_edge (
    .clk    (clk),
    .rst    (rst),
    .i_raw  (irq_src_i),
    .o_rise (w_rise)
  );

  assign w_eligible = r_pending & irq_mask_i;

  // Priority encoder: scan from the top down so the lowest index wins.
  // The exception ID is excluded defensively; it is unreachable for legal
  // IRQ_NUM values.
  always_comb begin
    w_win_id = IRQ_W'(ID_NONE);
    w_found  = 1'b0;
    for (int k = IRQ_NUM - 1; k >= 0; k--) begin
      if (w_eligible[k] && (IRQ_W'(k + 1) != IRQ_W'(ID_EXC))) begin
        w_win_id = IRQ_W'(k + 1);
        w_found  = 1'b1;
      end
    end
  end

  assign w_ack_fire = (r_state == ST_REQ) && irq_acknowledge_i;

  // Clear the pending bit of the acknowledged ID.
  always_comb begin
    w_clr = '0;
    for (int k = 0; k < IRQ_NUM; k++) begin
      if (w_ack_fire && (r_req_id == IRQ_W'(k + 1))) begin
        w_clr[k] = 1'b1;
      end
    end
  end

  // Next state plus next values of the registered outputs.
  always_comb begin
    w_next_state  = r_state;
    w_next_req_id = r_req_id;
    w_next_id_out = IRQ_W'(ID_NONE);
    w_next_active = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_next_state  = ST_REQ;
          w_next_req_id = w_win_id;
          w_next_id_out = w_win_id;
        end
      end
      ST_REQ: begin
        if (irq_acknowledge_i) begin
          w_next_state  = ST_SERVICE;
          w_next_active = 1'b1;
        end else begin
          // Request is never retracted, whatever pending/mask do.
          w_next_id_out = r_req_id;
        end
      end
      ST_SERVICE: begin
        if (irq_complete_i) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_active = 1'b1;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_req_id  <= '0;
      r_pending <= '0;
      r_id_out  <= '0;
      r_active  <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_req_id  <= w_next_req_id;
      // A set landing with the clear wins.
      r_pending <= (r_pending & ~w_clr) | w_rise;
      r_id_out  <= w_next_id_out;
      r_active  <= w_next_active;
    end
  end

  assign irq_flush_req_addr_o = r_id_out;
  assign irq_pending_o        = r_pending;
  assign irq_active_o         = r_active;
  assign irq_state_o          = r_state;

endmodule

// File: tb/tb_irq_arbiter.sv
module tb_irq_arbiter;
  import irq_arbiter_pkg::*;

  localparam int N = 8;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] irq_src_i = '0;
  logic [N-1:0] irq_mask_i = '1;
  logic [W-1:0] irq_flush_req_addr_o;
  logic         irq_acknowledge_i = 1'b0;
  logic         irq_complete_i = 1'b0;
  logic [N-1:0] irq_pending_o;
  logic         irq_active_o;
  logic [1:0]   irq_state_o;

  int n_tests = 0;
  int n_fail  = 0;

  // clock / reset
  always #5 clk = ~clk;

  irq_arbiter #(.IRQ_NUM(N), .IRQ_W(W)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .irq_src_i            (irq_src_i),
    .irq_mask_i           (irq_mask_i),
    .irq_flush_req_addr_o (irq_flush_req_addr_o),
    .irq_acknowledge_i    (irq_acknowledge_i),
    .irq_complete_i       (irq_complete_i),
    .irq_pending_o        (irq_pending_o),
    .irq_active_o         (irq_active_o),
    .irq_state_o          (irq_state_o)
  );

  // driver tasks: advance n active edges, land 1 time unit after the last
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_ack();
    irq_acknowledge_i = 1'b1;
    tick(1);
    irq_acknowledge_i = 1'b0;
  endtask

  task automatic pulse_complete();
    irq_complete_i = 1'b1;
    tick(1);
    irq_complete_i = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset
    #2;
    check("rst_id", 32'(irq_flush_req_addr_o), 32'h0);
    check("rst_active", 32'(irq_active_o), 32'h0);
    check("rst_pending", 32'(irq_pending_o), 32'h0);
    tick(2);
    rst = 1'b0;
    tick(1);
    check("idle_state", 32'(irq_state_o), 32'(ST_IDLE));

    // basic request: source 2 -> ID 3 after 4 edges
    irq_src_i = 8'h04;
    tick(3);
    check("basic_pend_e3", 32'(irq_pending_o), 32'h04);
    check("basic_id_e3", 32'(irq_flush_req_addr_o), 32'h0);
    tick(1);
    check("basic_id_e4", 32'(irq_flush_req_addr_o), 32'h3);
    check("basic_state_req", 32'(irq_state_o), 32'(ST_REQ));
    pulse_ack();
    check("basic_ack_id", 32'(irq_flush_req_addr_o), 32'h0);
    check("basic_ack_active", 32'(irq_active_o), 32'h1);
    check("basic_ack_pend", 32'(irq_pending_o), 32'h0);
    irq_src_i = 8'h00;
    pulse_complete();
    check("basic_cmp_state", 32'(irq_state_o), 32'(ST_IDLE));
    check("basic_cmp_active", 32'(irq_active_o), 32'h0);

    // priority: sources 5 and 1 together -> ID 2 first, then ID 6
    tick(1);
    irq_src_i = 8'h22;
    tick(4);
    check("prio_first", 32'(irq_flush_req_addr_o), 32'h2);
    check("prio_pend", 32'(irq_pending_o), 32'h22);
    pulse_ack();
    check("prio_ack_pend", 32'(irq_pending_o), 32'h20);
    tick(3);
    check("prio_no_nest", 32'(irq_flush_req_addr_o), 32'h0);
    check("prio_svc_state", 32'(irq_state_o), 32'(ST_SERVICE));
    pulse_complete();
    check("prio_cmp_id", 32'(irq_flush_req_addr_o), 32'h0);
    tick(1);
    check("prio_second", 32'(irq_flush_req_addr_o), 32'h6);

    // stray complete in REQ: nothing changes
    pulse_complete();
    check("stray_cmp_id", 32'(irq_flush_req_addr_o), 32'h6);
    check("stray_cmp_state", 32'(irq_state_o), 32'(ST_REQ));
    pulse_ack();
    irq_src_i = 8'h00;
    pulse_complete();
    // stray ack in IDLE: nothing changes
    pulse_ack();
    check("stray_ack_state", 32'(irq_state_o), 32'(ST_IDLE));
    check("stray_ack_id", 32'(irq_flush_req_addr_o), 32'h0);
    check("stray_ack_active", 32'(irq_active_o), 32'h0);

    // masking: source 3 pending but disabled
    irq_mask_i = 8'hF7;
    irq_src_i  = 8'h08;
    tick(6);
    check("mask_no_req", 32'(irq_flush_req_addr_o), 32'h0);
    check("mask_pend", 32'(irq_pending_o), 32'h08);
    irq_mask_i = 8'hFF;
    tick(1);
    check("mask_enable", 32'(irq_flush_req_addr_o), 32'h4);
    irq_mask_i = 8'hF7;
    tick(2);
    check("mask_no_retract", 32'(irq_flush_req_addr_o), 32'h4);
    pulse_ack();
    check("mask_ack_pend", 32'(irq_pending_o), 32'h00);
    irq_mask_i = 8'hFF;
    irq_src_i  = 8'h00;
    pulse_complete();

    // set/clear collision on source 0
    irq_src_i = 8'h01;
    tick(4);
    check("coll_req", 32'(irq_flush_req_addr_o), 32'h1);
    irq_src_i = 8'h00;
    tick(2);
    irq_src_i = 8'h01;
    tick(2);
    // the re-edge sets pending on the same edge that the ack clears it
    pulse_ack();
    check("coll_pend", 32'(irq_pending_o), 32'h01);
    check("coll_active", 32'(irq_active_o), 32'h1);
    pulse_complete();
    tick(1);
    check("coll_reissue", 32'(irq_flush_req_addr_o), 32'h1);
    pulse_ack();
    check("coll_clear", 32'(irq_pending_o), 32'h00);

    // reset mid-service
    irq_src_i = 8'h00;
    tick(2);
    check("svc_before_rst", 32'(irq_active_o), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_active", 32'(irq_active_o), 32'h0);
    check("async_rst_state", 32'(irq_state_o), 32'(ST_IDLE));
    check("async_rst_id", 32'(irq_flush_req_addr_o), 32'h0);
    tick(2);
    rst = 1'b0;
    tick(3);
    check("post_rst_pend", 32'(irq_pending_o), 32'h00);
    check("post_rst_state", 32'(irq_state_o), 32'(ST_IDLE));
    check("post_rst_id", 32'(irq_flush_req_addr_o), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
